// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/even/odd parity, 1 or 2 stop bits,
// 3-sample majority voting and a one-entry valid/ready output register.
module uart_rx_cfg #(
  parameter int unsigned clk_frequency = 27,
  parameter int unsigned baud_rate     = 115200,
  parameter int unsigned data_bits     = 8,
  parameter int unsigned parity_mode   = 0,
  parameter int unsigned stop_bits     = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_data_bit,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [data_bits-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun
);

  localparam int unsigned CLK_CYCLE = (clk_frequency * 1000000) / baud_rate;
  localparam int unsigned HALF      = CLK_CYCLE / 2;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned IDX_W     = 4;
  localparam logic [CNT_W-1:0] VOTE_AT  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLK_CYCLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(data_bits - 1);
  localparam logic PAR_EN   = 1'(parity_mode != 0);
  localparam logic PAR_ODD  = 1'(parity_mode == 2);
  localparam logic TWO_STOP = 1'(stop_bits == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 sync_q1, sync_q2;
  logic [1:0]           hist;
  logic [data_bits-1:0] shreg;
  logic                 par_q, stop0_q, stop_idx;

  logic [2:0] samp_c;
  logic       vote_c, at_vote_c, at_end_c, done_c;
  logic       frame_err_c, break_c, parity_err_c;

  // Three consecutive synchronised samples: counts half-3, half-2, half-1 at the vote point
  assign samp_c    = {hist, sync_q2};
  assign vote_c    = (samp_c[0] & samp_c[1]) | (samp_c[0] & samp_c[2]) | (samp_c[1] & samp_c[2]);
  assign at_vote_c = (cnt == VOTE_AT);
  assign at_end_c  = (cnt == BIT_END);

  assign frame_err_c  = ~vote_c | (TWO_STOP & ~stop0_q);
  assign break_c      = (shreg == '0) & (~PAR_EN | ~par_q) & ~vote_c & (~TWO_STOP | ~stop0_q);
  assign parity_err_c = PAR_EN & ((^shreg) ^ par_q ^ PAR_ODD);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and completion decode
  always_comb begin
    state_nxt = state;
    done_c    = 1'b0;
    case (state)
      S_IDLE:     if (hist[0] && !sync_q2) state_nxt = S_START;
      S_START: begin
        if (at_vote_c && vote_c) state_nxt = S_IDLE;
        else if (at_end_c)       state_nxt = S_DATA;
      end
      S_DATA:     if (at_end_c && bit_idx == LAST_IDX) state_nxt = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY:   if (at_end_c) state_nxt = S_STOP;
      S_STOP: begin
        if (at_vote_c && (!TWO_STOP || stop_idx)) begin
          done_c    = 1'b1;
          state_nxt = break_c ? S_BRK_WAIT : S_IDLE;
        end
      end
      S_BRK_WAIT: if (sync_q2) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Synchroniser, bit timing and frame capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q1  <= 1'b1;
      sync_q2  <= 1'b1;
      hist     <= 2'b11;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      stop0_q  <= 1'b0;
      stop_idx <= 1'b0;
    end else begin
      sync_q1 <= i_data_bit;
      sync_q2 <= sync_q1;
      hist    <= {hist[0], sync_q2};

      if (state_nxt != state || at_end_c || state == S_IDLE || state == S_BRK_WAIT) cnt <= '0;
      else cnt <= cnt + CNT_W'(1);

      if (state != S_DATA) bit_idx <= '0;
      else if (at_end_c)   bit_idx <= bit_idx + IDX_W'(1);

      // LSB arrives first, so shifting right leaves bit 0 in place after the last data bit
      if (state == S_IDLE && state_nxt == S_START) begin
        shreg <= '0;
        par_q <= 1'b0;
      end else if (state == S_DATA && at_vote_c) begin
        shreg <= {vote_c, shreg[data_bits-1:1]};
      end else if (state == S_PARITY && at_vote_c) begin
        par_q <= vote_c;
      end

      if (state != S_STOP) stop_idx <= 1'b0;
      else if (at_end_c)   stop_idx <= 1'b1;

      if (state == S_STOP && at_vote_c && !stop_idx) stop0_q <= vote_c;
    end
  end

  // One-entry output register; a full, unaccepted register drops the new frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (done_c) begin
        if (!o_valid || i_ready) begin
          o_valid      <= 1'b1;
          o_data       <= shreg;
          o_parity_err <= parity_err_c;
          o_frame_err  <= frame_err_c;
          o_break      <= break_c;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
